// File: rtl/galaga_pixel_pipe.sv
// rtl/galaga_pixel_pipe.sv - three-stage pixel classifier with per-frame object snapshot and collision flags
module galaga_pixel_pipe #(
  parameter int N_ENEMY   = 15,
  parameter int N_EBULLET = 31,
  parameter int N_PBULLET = 15,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int ENEMY_W   = 36,
  parameter int ENEMY_H   = 24,
  parameter int BULLET_W  = 4,
  parameter int BULLET_H  = 16,
  parameter int PLAYER_W  = 24,
  parameter int PLAYER_H  = 36,
  parameter int PLAYER_Y  = 280
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pix_valid,
  input  logic                           frame_start,
  input  logic [X_W-1:0]                 pix_x,
  input  logic [Y_W-1:0]                 pix_y,
  input  logic [N_ENEMY-1:0]             enemyState,
  input  logic [N_ENEMY*(X_W+Y_W)-1:0]   enemyPosition,
  input  logic [N_EBULLET-1:0]           enemyBulletState,
  input  logic [N_EBULLET*(X_W+Y_W)-1:0] enemyBulletPosition,
  input  logic                           playerState,
  input  logic [X_W-1:0]                 playerPosition,
  input  logic [N_PBULLET-1:0]           playerBulletState,
  input  logic [N_PBULLET*(X_W+Y_W)-1:0] playerBulletPosition,
  output logic                           out_valid,
  output logic [X_W-1:0]                 out_x,
  output logic [Y_W-1:0]                 out_y,
  output logic [2:0]                     pixelState,
  output logic [N_ENEMY-1:0]             enemy_hit,
  output logic [N_PBULLET-1:0]           pbullet_hit,
  output logic                           player_hit,
  output logic                           hit_valid
);

  localparam int SLOT_W = X_W + Y_W;
  localparam logic [X_W:0]   ENEMY_WX  = (X_W+1)'(ENEMY_W);
  localparam logic [Y_W:0]   ENEMY_HY  = (Y_W+1)'(ENEMY_H);
  localparam logic [X_W:0]   BULLET_WX = (X_W+1)'(BULLET_W);
  localparam logic [Y_W:0]   BULLET_HY = (Y_W+1)'(BULLET_H);
  localparam logic [X_W:0]   PLAYER_WX = (X_W+1)'(PLAYER_W);
  localparam logic [Y_W:0]   PLAYER_HY = (Y_W+1)'(PLAYER_H);
  localparam logic [Y_W-1:0] PLAYER_YT = Y_W'(PLAYER_Y);

  // Box ends carry one extra bit so an object near the right/bottom edge clips instead of wrapping.
  function automatic logic inBox(input logic [X_W-1:0] ox, input logic [Y_W-1:0] oy,
                                 input logic [X_W-1:0] px, input logic [Y_W-1:0] py,
                                 input logic [X_W:0] w, input logic [Y_W:0] h);
    logic [X_W:0] xEnd;
    logic [Y_W:0] yEnd;
    xEnd = {1'b0, ox} + w;
    yEnd = {1'b0, oy} + h;
    return (px >= ox) && ({1'b0, px} < xEnd) && (py >= oy) && ({1'b0, py} < yEnd);
  endfunction

  logic                           s1Valid, s1Frame;
  logic [X_W-1:0]                 s1X;
  logic [Y_W-1:0]                 s1Y;
  logic [N_ENEMY-1:0]             shEnemyState;
  logic [N_ENEMY*SLOT_W-1:0]      shEnemyPos;
  logic [N_EBULLET-1:0]           shEbState;
  logic [N_EBULLET*SLOT_W-1:0]    shEbPos;
  logic [N_PBULLET-1:0]           shPbState;
  logic [N_PBULLET*SLOT_W-1:0]    shPbPos;
  logic                           shPlayerState;
  logic [X_W-1:0]                 shPlayerX;
  logic [N_ENEMY-1:0]             ehNext, eh;
  logic [N_EBULLET-1:0]           ebhNext, ebh;
  logic [N_PBULLET-1:0]           pbhNext, pbh;
  logic                           phNext, ph;
  logic                           s2Valid, s2Frame;
  logic [X_W-1:0]                 s2X;
  logic [Y_W-1:0]                 s2Y;
  logic [N_ENEMY-1:0]             accEnemy, accEnemyC;
  logic [N_PBULLET-1:0]           accPb, accPbC;
  logic                           accPlayer, accPlayerC;
  logic [2:0]                     codeNext;

  wire snapshot = pix_valid && frame_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid       <= 1'b0;
      s1Frame       <= 1'b0;
      s1X           <= '0;
      s1Y           <= '0;
      shEnemyState  <= '0;
      shEbState     <= '0;
      shPbState     <= '0;
      shPlayerState <= 1'b0;
    end else begin
      s1Valid <= pix_valid;
      s1Frame <= snapshot;
      s1X     <= pix_x;
      s1Y     <= pix_y;
      if (snapshot) begin
        shEnemyState  <= enemyState;
        shEbState     <= enemyBulletState;
        shPbState     <= playerBulletState;
        shPlayerState <= playerState;
      end
    end
  end

  // Positions only matter while the matching state bit is set, so they skip reset.
  always_ff @(posedge clk) begin
    if (snapshot) begin
      shEnemyPos <= enemyPosition;
      shEbPos    <= enemyBulletPosition;
      shPbPos    <= playerBulletPosition;
      shPlayerX  <= playerPosition;
    end
  end

  for (genvar i = 0; i < N_ENEMY; i++) begin : gEnemy
    assign ehNext[i] = shEnemyState[i] && inBox(shEnemyPos[i*SLOT_W +: X_W],
        shEnemyPos[i*SLOT_W+X_W +: Y_W], s1X, s1Y, ENEMY_WX, ENEMY_HY);
  end
  for (genvar i = 0; i < N_EBULLET; i++) begin : gEbullet
    assign ebhNext[i] = shEbState[i] && inBox(shEbPos[i*SLOT_W +: X_W],
        shEbPos[i*SLOT_W+X_W +: Y_W], s1X, s1Y, BULLET_WX, BULLET_HY);
  end
  for (genvar i = 0; i < N_PBULLET; i++) begin : gPbullet
    assign pbhNext[i] = shPbState[i] && inBox(shPbPos[i*SLOT_W +: X_W],
        shPbPos[i*SLOT_W+X_W +: Y_W], s1X, s1Y, BULLET_WX, BULLET_HY);
  end
  assign phNext = shPlayerState && inBox(shPlayerX, PLAYER_YT, s1X, s1Y, PLAYER_WX, PLAYER_HY);

  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid <= 1'b0;
      s2Frame <= 1'b0;
      s2X     <= '0;
      s2Y     <= '0;
      eh      <= '0;
      ebh     <= '0;
      pbh     <= '0;
      ph      <= 1'b0;
    end else begin
      s2Valid <= s1Valid;
      s2Frame <= s1Frame;
      s2X     <= s1X;
      s2Y     <= s1Y;
      eh      <= ehNext;
      ebh     <= ebhNext;
      pbh     <= pbhNext;
      ph      <= phNext;
    end
  end

  assign accEnemyC  = eh & {N_ENEMY{|pbh}};
  assign accPbC     = pbh & {N_PBULLET{|eh}};
  assign accPlayerC = ph & (|eh | |ebh);

  always_comb begin
    codeNext = 3'b000;
    if (!s2Valid)  codeNext = 3'b000;
    else if (ph)   codeNext = 3'b011;
    else if (|pbh) codeNext = 3'b100;
    else if (|eh)  codeNext = 3'b001;
    else if (|ebh) codeNext = 3'b010;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      pixelState  <= 3'b000;
      accEnemy    <= '0;
      accPb       <= '0;
      accPlayer   <= 1'b0;
      enemy_hit   <= '0;
      pbullet_hit <= '0;
      player_hit  <= 1'b0;
      hit_valid   <= 1'b0;
    end else begin
      out_valid  <= s2Valid;
      out_x      <= s2X;
      out_y      <= s2Y;
      pixelState <= codeNext;
      hit_valid  <= 1'b0;
      if (s2Valid && s2Frame) begin
        enemy_hit   <= accEnemy;
        pbullet_hit <= accPb;
        player_hit  <= accPlayer;
        hit_valid   <= 1'b1;
        accEnemy    <= accEnemyC;
        accPb       <= accPbC;
        accPlayer   <= accPlayerC;
      end else if (s2Valid) begin
        accEnemy  <= accEnemy | accEnemyC;
        accPb     <= accPb | accPbC;
        accPlayer <= accPlayer | accPlayerC;
      end
    end
  end

endmodule

// File: tb/tb_galaga_pixel_pipe.sv
// tb/tb_galaga_pixel_pipe.sv - scoreboard bench for galaga_pixel_pipe
module tb_galaga_pixel_pipe;
  localparam int NE = 15, NEB = 31, NPB = 15, XW = 10, YW = 9, SW = XW + YW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_valid = 1'b0, frame_start = 1'b0;
  logic [XW-1:0] pix_x = '0;
  logic [YW-1:0] pix_y = '0;
  logic [NE-1:0] enemyState = '0;
  logic [NE*SW-1:0] enemyPosition = '0;
  logic [NEB-1:0] enemyBulletState = '0;
  logic [NEB*SW-1:0] enemyBulletPosition = '0;
  logic playerState = 1'b0;
  logic [XW-1:0] playerPosition = '0;
  logic [NPB-1:0] playerBulletState = '0;
  logic [NPB*SW-1:0] playerBulletPosition = '0;
  logic out_valid;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic [2:0] pixelState;
  logic [NE-1:0] enemy_hit;
  logic [NPB-1:0] pbullet_hit;
  logic player_hit, hit_valid;

  galaga_pixel_pipe dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .frame_start(frame_start),
    .pix_x(pix_x), .pix_y(pix_y),
    .enemyState(enemyState), .enemyPosition(enemyPosition),
    .enemyBulletState(enemyBulletState), .enemyBulletPosition(enemyBulletPosition),
    .playerState(playerState), .playerPosition(playerPosition),
    .playerBulletState(playerBulletState), .playerBulletPosition(playerBulletPosition),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .pixelState(pixelState),
    .enemy_hit(enemy_hit), .pbullet_hit(pbullet_hit), .player_hit(player_hit),
    .hit_valid(hit_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [2:0]    code;
    logic [31:0]   cyc;
  } pixExp_t;
  typedef struct packed {
    logic [NE-1:0]  e;
    logic [NPB-1:0] p;
    logic           pl;
  } hitExp_t;

  pixExp_t pixQ[$];
  hitExp_t hitQ[$];
  int nChecks = 0;
  int nFail = 0;
  logic [31:0] cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    pixExp_t pe;
    hitExp_t he;
    if (out_valid) begin
      nChecks++;
      if (pixQ.size() == 0) begin
        nFail++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d code=%b, required none", out_x, out_y, pixelState);
      end else begin
        pe = pixQ.pop_front();
        if (out_x !== pe.x || out_y !== pe.y || pixelState !== pe.code || cyc !== pe.cyc) begin
          nFail++;
          $display("FAIL pixel(%0d,%0d): got x=%0d y=%0d code=%b cyc=%0d, required code=%b cyc=%0d",
                   pe.x, pe.y, out_x, out_y, pixelState, cyc, pe.code, pe.cyc);
        end
      end
    end else begin
      nChecks++;
      if (pixelState !== 3'b000) begin
        nFail++;
        $display("FAIL bubble_code: got %b, required 000", pixelState);
      end
    end
    if (hit_valid) begin
      nChecks++;
      if (hitQ.size() == 0) begin
        nFail++;
        $display("FAIL unexpected_hit_valid: got e=%h p=%h pl=%b, required no pulse", enemy_hit, pbullet_hit, player_hit);
      end else begin
        he = hitQ.pop_front();
        if (enemy_hit !== he.e || pbullet_hit !== he.p || player_hit !== he.pl) begin
          nFail++;
          $display("FAIL hit_publish: got e=%h p=%h pl=%b, required e=%h p=%h pl=%b",
                   enemy_hit, pbullet_hit, player_hit, he.e, he.p, he.pl);
        end
      end
    end
  end

  task automatic pix(input int x, input int y, input bit fs, input logic [2:0] code, input bit push = 1'b1);
    pixExp_t pe;
    @(posedge clk); #1;
    pix_valid = 1'b1; frame_start = fs;
    pix_x = XW'(x); pix_y = YW'(y);
    if (push) begin
      pe.x = XW'(x); pe.y = YW'(y); pe.code = code; pe.cyc = cyc + 3;
      pixQ.push_back(pe);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pix_valid = 1'b0; frame_start = 1'b0;
    end
  endtask

  task automatic expHit(input logic [NE-1:0] e, input logic [NPB-1:0] p, input logic pl);
    hitExp_t he;
    he.e = e; he.p = p; he.pl = pl;
    hitQ.push_back(he);
  endtask

  task automatic clearObjs();
    enemyState = '0; enemyBulletState = '0; playerBulletState = '0; playerState = 1'b0;
  endtask

  task automatic setEnemy(input int i, input int x, input int y);
    enemyState[i] = 1'b1;
    enemyPosition[i*SW +: SW] = {YW'(y), XW'(x)};
  endtask

  task automatic setPb(input int i, input int x, input int y);
    playerBulletState[i] = 1'b1;
    playerBulletPosition[i*SW +: SW] = {YW'(y), XW'(x)};
  endtask

  task automatic setEb(input int i, input int x, input int y);
    enemyBulletState[i] = 1'b1;
    enemyBulletPosition[i*SW +: SW] = {YW'(y), XW'(x)};
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] req);
    nChecks++;
    if (got !== req) begin
      nFail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("reset_out_valid", 32'(out_valid), 0);
    checkVal("reset_enemy_hit", 32'(enemy_hit), 0);
    checkVal("reset_pbullet_hit", 32'(pbullet_hit), 0);
    checkVal("reset_player_hit", 32'(player_hit), 0);
    checkVal("reset_hit_valid", 32'(hit_valid), 0);
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 5; i++) pix(10 + i, 20, 1'b0, 3'b000);
    idle(4);

    setEnemy(0, 100, 50); setPb(0, 110, 55);
    pix(100, 50, 1'b1, 3'b001); expHit('0, '0, 1'b0);
    pix(111, 60, 1'b0, 3'b100);
    idle(1);

    clearObjs(); setEnemy(0, 1010, 50);
    pix(1015, 55, 1'b1, 3'b001); expHit(15'h0001, 15'h0001, 1'b0);
    for (int x = 0; x < 4; x++) pix(x, 55, 1'b0, 3'b000);
    pix(1023, 55, 1'b0, 3'b001);
    idle(1);

    clearObjs(); setEnemy(2, 200, 100);
    pix(0, 0, 1'b1, 3'b000); expHit('0, '0, 1'b0);
    pix(205, 105, 1'b0, 3'b001);
    setEnemy(2, 300, 100);
    @(posedge clk); #1; pix_valid = 1'b0; frame_start = 1'b1;
    pix(305, 105, 1'b0, 3'b000);
    pix(200, 123, 1'b0, 3'b001);
    pix(236, 105, 1'b0, 3'b000);
    pix(200, 124, 1'b0, 3'b000);
    idle(1);

    clearObjs(); setEnemy(3, 40, 40); setPb(5, 50, 45);
    pix(0, 0, 1'b1, 3'b000); expHit('0, '0, 1'b0);
    pix(51, 50, 1'b0, 3'b100);
    pix(45, 45, 1'b0, 3'b001);
    idle(1);

    clearObjs(); playerState = 1'b1; playerPosition = 10'd400; setEb(0, 402, 310);
    pix(0, 0, 1'b1, 3'b000); expHit(15'h0008, 15'h0020, 1'b0);
    pix(401, 285, 1'b0, 3'b011);
    pix(403, 320, 1'b0, 3'b010);
    pix(424, 290, 1'b0, 3'b000);
    pix(403, 312, 1'b0, 3'b011);
    idle(1);

    clearObjs(); setEnemy(3, 40, 40); setPb(5, 50, 45);
    pix(0, 0, 1'b1, 3'b000); expHit('0, '0, 1'b1);
    pix(51, 50, 1'b0, 3'b100);
    idle(4);
    pix(52, 50, 1'b0, 3'b100, 1'b0);
    @(posedge clk); #1; rst = 1'b1; pix_valid = 1'b0; frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    clearObjs();
    pix(0, 0, 1'b1, 3'b000); expHit('0, '0, 1'b0);
    idle(1);

    setEnemy(3, 40, 40); setPb(5, 50, 45);
    pix(51, 50, 1'b1, 3'b100); expHit('0, '0, 1'b0);
    pix(0, 0, 1'b1, 3'b000); expHit(15'h0008, 15'h0020, 1'b0);
    pix(0, 0, 1'b1, 3'b000); expHit('0, '0, 1'b0);
    idle(6);

    checkVal("pixel_queue_drained", 32'(pixQ.size()), 0);
    checkVal("hit_queue_drained", 32'(hitQ.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end
endmodule
